// File: rtl/aoc3_pkg.sv
// Shared state type, ASCII constants and digit helpers for the day-3 line sequencer.
// DATA_WIDTH normally comes from common.svh; a 64-bit default keeps standalone builds complete.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

package aoc3_pkg;

    typedef enum logic [1:0] {
        ST_FEED  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } seq_state_e;

    localparam logic [7:0] CH_ZERO = 8'h30;
    localparam logic [7:0] CH_NINE = 8'h39;
    localparam logic [7:0] CH_LF   = 8'h0A;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_ZERO) && (c <= CH_NINE);
    endfunction

    // ASCII '0'..'9' carry their value in the low nibble.
    function automatic logic [3:0] digit_val(input logic [3:0] lo_nibble);
        return lo_nibble;
    endfunction

endpackage

// File: rtl/aoc3_sum_acc.sv
// Line-result accumulator: adds the zero-extended selector result and counts lines when enabled.
module aoc3_sum_acc #(
    parameter int DW        = 64,
    parameter int SUM_WIDTH = 64
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 en,
    input  logic [DW-1:0]        value,
    output logic [SUM_WIDTH-1:0] total,
    output logic [15:0]          line_count
);
    logic [SUM_WIDTH-1:0] total_q, total_d;
    logic [15:0]          count_q, count_d;

    always_comb begin
        total_d = total_q;
        count_d = count_q;
        if (en) begin
            total_d = total_q + SUM_WIDTH'(value);
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            total_q <= '0;
            count_q <= '0;
        end else begin
            total_q <= total_d;
            count_q <= count_d;
        end
    end

    assign total      = total_q;
    assign line_count = count_q;
endmodule

// File: rtl/aoc3_line_sequencer.sv
// Byte-stream front end for the day-3 digit selector: feeds digits, closes lines, sums results.
// Optional AOC3_LINE_CHECK_EN flags lines whose length differs from LINE_LEN and skips their result.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module aoc3_line_sequencer
    import aoc3_pkg::*;
#(
    parameter int LINE_LEN  = 15,
    parameter int SUM_WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [7:0]             char_in,
    input  logic                   char_valid,
    input  logic                   char_last,
    output logic                   char_ready,
    output logic [`DATA_WIDTH-1:0] sel_data_in,
    output logic                   sel_data_in_valid,
    output logic [`DATA_WIDTH-1:0] sel_nums_left,
    output logic                   sel_newline,
    input  logic [`DATA_WIDTH-1:0] sel_data_out,
    input  logic                   sel_data_out_valid,
    output logic [SUM_WIDTH-1:0]   total,
    output logic [15:0]            line_count,
    output logic                   done,
    output logic                   err_len
);
    localparam int DW = `DATA_WIDTH;
    localparam int CW = $clog2(LINE_LEN + 1);
    localparam logic [CW-1:0] LEN_C = CW'(LINE_LEN);

    seq_state_e    state_q, state_d;
    logic [CW-1:0] col_q, col_d, col_n;
    logic          dropped_q, dropped_d, drop_n;
    logic          last_q, last_d;
    logic          skip_q, skip_d;
    logic          nl_pend_q, nl_pend_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;
    logic [DW-1:0] din_q, din_d;
    logic [DW-1:0] left_q, left_d;
    logic          din_vld_q, din_vld_d;
    logic          nl_q, nl_d;
    logic          acc_en, close_line, line_bad;

    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        dropped_d  = dropped_q;
        last_d     = last_q;
        skip_d     = skip_q;
        nl_pend_d  = 1'b0;
        nl_d       = nl_pend_q;
        din_d      = '0;
        din_vld_d  = 1'b0;
        left_d     = '0;
        acc_en     = 1'b0;
        close_line = 1'b0;
        line_bad   = 1'b0;
        col_n      = col_q;
        drop_n     = dropped_q;

        case (state_q)
            ST_FEED: begin
                if (char_valid && ready_q) begin
                    if (is_digit(char_in)) begin
                        if (col_q < LEN_C) begin
                            din_d     = DW'(digit_val(char_in[3:0]));
                            din_vld_d = 1'b1;
                            left_d    = DW'(LINE_LEN - 1) - DW'(col_q);
                            col_n     = col_q + CW'(1);
                        end else begin
                            drop_n = 1'b1;
                        end
                        // A final digit closes its line one cycle after its own strobe.
                        close_line = char_last;
                        nl_pend_d  = char_last;
                    end else if (char_last || (char_in == CH_LF)) begin
                        // A trailing non-LF byte still closes any pending digits.
                        if (col_q != '0) begin
                            close_line = 1'b1;
                            nl_d       = 1'b1;
                        end else if (char_last) begin
                            state_d = ST_DONE;
                        end
                    end
                    col_d     = col_n;
                    dropped_d = drop_n;
                    if (close_line) begin
`ifdef AOC3_LINE_CHECK_EN
                        line_bad = (col_n != LEN_C) || drop_n;
`else
                        line_bad = 1'b0;
`endif
                        state_d   = ST_DRAIN;
                        last_d    = char_last;
                        skip_d    = line_bad;
                        col_d     = '0;
                        dropped_d = 1'b0;
                    end
                end
            end
            ST_DRAIN: begin
                if (sel_data_out_valid) begin
                    acc_en  = !skip_q;
                    state_d = last_q ? ST_DONE : ST_FEED;
                end
            end
            default: ;
        endcase

        ready_d = (state_d == ST_FEED);
        done_d  = (state_d == ST_DONE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_FEED;
            col_q     <= '0;
            dropped_q <= 1'b0;
            last_q    <= 1'b0;
            skip_q    <= 1'b0;
            nl_pend_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            din_q     <= '0;
            left_q    <= '0;
            din_vld_q <= 1'b0;
            nl_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            dropped_q <= dropped_d;
            last_q    <= last_d;
            skip_q    <= skip_d;
            nl_pend_q <= nl_pend_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            din_q     <= din_d;
            left_q    <= left_d;
            din_vld_q <= din_vld_d;
            nl_q      <= nl_d;
        end
    end

`ifdef AOC3_LINE_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q | (close_line & line_bad);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err_len = err_q;
`else
    assign err_len = 1'b0;
`endif

    aoc3_sum_acc #(
        .DW        (DW),
        .SUM_WIDTH (SUM_WIDTH)
    ) u_sum_acc (
        .clock      (clock),
        .reset_n    (reset_n),
        .en         (acc_en),
        .value      (sel_data_out),
        .total      (total),
        .line_count (line_count)
    );

    assign char_ready        = ready_q;
    assign done              = done_q;
    assign sel_data_in       = din_q;
    assign sel_data_in_valid = din_vld_q;
    assign sel_nums_left     = left_q;
    assign sel_newline       = nl_q;
endmodule

// File: tb/tb_aoc3_line_sequencer.sv
// Self-checking bench for aoc3_line_sequencer: a selector stand-in answers each line, and a
// text-level reference model predicts totals, line counts, newline pulses and err_len.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif

module tb_aoc3_line_sequencer;
    localparam int LINE_LEN  = 15;
    localparam int SUM_WIDTH = 64;
    localparam int DW        = `DATA_WIDTH;
`ifdef AOC3_LINE_CHECK_EN
    localparam bit CHECK_MODE = 1'b1;
`else
    localparam bit CHECK_MODE = 1'b0;
`endif

    logic                 clock = 1'b0;
    logic                 reset_n = 1'b0;
    logic [7:0]           char_in = 8'h00;
    logic                 char_valid = 1'b0;
    logic                 char_last = 1'b0;
    logic                 char_ready;
    logic [DW-1:0]        sel_data_in;
    logic                 sel_data_in_valid;
    logic [DW-1:0]        sel_nums_left;
    logic                 sel_newline;
    logic [DW-1:0]        sel_data_out = '0;
    logic                 sel_data_out_valid = 1'b0;
    logic [SUM_WIDTH-1:0] total;
    logic [15:0]          line_count;
    logic                 done;
    logic                 err_len;

    aoc3_line_sequencer #(
        .LINE_LEN  (LINE_LEN),
        .SUM_WIDTH (SUM_WIDTH)
    ) dut (
        .clock              (clock),
        .reset_n            (reset_n),
        .char_in            (char_in),
        .char_valid         (char_valid),
        .char_last          (char_last),
        .char_ready         (char_ready),
        .sel_data_in        (sel_data_in),
        .sel_data_in_valid  (sel_data_in_valid),
        .sel_nums_left      (sel_nums_left),
        .sel_newline        (sel_newline),
        .sel_data_out       (sel_data_out),
        .sel_data_out_valid (sel_data_out_valid),
        .total              (total),
        .line_count         (line_count),
        .done               (done),
        .err_len            (err_len)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Largest number formed by picking k digits in order (greedy leftmost maximum).
    function automatic longint unsigned best_k(input int d[$], input int k);
        int n, kk, start, bi;
        longint unsigned v;
        n  = (d.size() > LINE_LEN) ? LINE_LEN : d.size();
        kk = (k > n) ? n : k;
        v = 0;
        start = 0;
        for (int i = 0; i < kk; i++) begin
            bi = start;
            for (int j = start; j <= n - (kk - i); j++)
                if (d[j] > d[bi]) bi = j;
            v = v * 10 + longint'(d[bi]);
            start = bi + 1;
        end
        return v;
    endfunction

    // ---------------- stimulus stream and reference model ----------------
    logic [7:0]      stream_q[$];
    longint unsigned exp_total;
    int              exp_cnt;
    int              exp_lines;
    bit              exp_err;

    task automatic add_str(input string s);
        for (int i = 0; i < s.len(); i++) stream_q.push_back(s[i]);
    endtask

    task automatic build_example();
        stream_q.delete();
        add_str("987654321111111\n");
        add_str("811111111111119\n");
        add_str("234234234234278\n");
        add_str("818181911112111\n");
    endtask

    task automatic build_random();
        int nl, nd;
        bit with_lf;
        stream_q.delete();
        nl = $urandom_range(1, 6);
        for (int l = 0; l < nl; l++) begin
            nd = $urandom_range(0, 1) ? LINE_LEN : $urandom_range(0, 18);
            for (int d = 0; d < nd; d++) begin
                if ($urandom_range(0, 9) == 0) stream_q.push_back(8'h20);
                stream_q.push_back(8'h30 + 8'($urandom_range(0, 9)));
            end
            with_lf = (l != nl - 1) || ($urandom_range(0, 1) == 1);
            if (with_lf) begin
                if ($urandom_range(0, 3) == 0) stream_q.push_back(8'h0D);
                stream_q.push_back(8'h0A);
                if ($urandom_range(0, 4) == 0 && l != nl - 1) stream_q.push_back(8'h0A);
            end
        end
        if (stream_q.size() == 0) stream_q.push_back(8'h0A);
    endtask

    // Splits the text into lines and scores each, independent of any cycle timing.
    task automatic ref_model(input int k);
        int digs[$];
        bit endl;
        exp_total = 0;
        exp_cnt   = 0;
        exp_lines = 0;
        exp_err   = 1'b0;
        for (int i = 0; i < stream_q.size(); i++) begin
            if (stream_q[i] >= 8'h30 && stream_q[i] <= 8'h39) digs.push_back(int'(stream_q[i]) - 48);
            endl = (stream_q[i] == 8'h0A) || (i == stream_q.size() - 1);
            if (endl && digs.size() > 0) begin
                exp_lines++;
                if (CHECK_MODE && digs.size() != LINE_LEN) begin
                    exp_err = 1'b1;
                end else begin
                    exp_total += best_k(digs, k);
                    exp_cnt++;
                end
                digs.delete();
            end
        end
    endtask

    // ---------------- selector stand-in ----------------
    int              sel_k = 2;
    int              rx_digits[$];
    int              resp_cnt = 0;
    longint unsigned resp_val = 0;
    bit              draining = 1'b0;
    int              nl_seen = 0;

    always @(negedge clock) begin
        sel_data_out_valid = 1'b0;
        if (!reset_n) begin
            rx_digits.delete();
            resp_cnt = 0;
            draining = 1'b0;
        end else begin
            if (draining) check_eq("ready_low_in_drain", 64'(char_ready), 64'd0);
            if (sel_data_in_valid) begin
                check_eq("nums_left", sel_nums_left, 64'(LINE_LEN - 1 - rx_digits.size()));
                rx_digits.push_back(int'(sel_data_in));
            end
            if (sel_newline) begin
                nl_seen++;
                resp_val = best_k(rx_digits, sel_k);
                rx_digits.delete();
                resp_cnt = $urandom_range(1, 4);
                draining = 1'b1;
            end else if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    sel_data_out       = DW'(resp_val);
                    sel_data_out_valid = 1'b1;
                    draining           = 1'b0;
                end
            end else if ((char_ready || done) && $urandom_range(0, 15) == 0) begin
                // Stray result while not draining must be ignored.
                sel_data_out       = DW'($urandom_range(1, 999));
                sel_data_out_valid = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(negedge clock);
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_last  = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_ready", 64'(char_ready), 64'd0);
        check_eq("rst_done", 64'(done), 64'd0);
        check_eq("rst_total", total, 64'd0);
        check_eq("rst_count", 64'(line_count), 64'd0);
        check_eq("rst_sel_valid", 64'(sel_data_in_valid), 64'd0);
        check_eq("rst_newline", 64'(sel_newline), 64'd0);
        check_eq("rst_err", 64'(err_len), 64'd0);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int t;
        repeat ($urandom_range(0, 2)) @(negedge clock);
        char_in    = b;
        char_valid = 1'b1;
        char_last  = last;
        t = 0;
        while (!char_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) check_eq("ready_timeout", 64'(char_ready), 64'd1);
        @(negedge clock);
        char_valid = 1'b0;
        char_last  = 1'b0;
    endtask

    task automatic run_stream(input int k);
        int t;
        sel_k   = k;
        nl_seen = 0;
        ref_model(k);
        for (int i = 0; i < stream_q.size(); i++)
            send_byte(stream_q[i], i == stream_q.size() - 1);
        t = 0;
        while (!done && t < 500) begin
            @(negedge clock);
            t++;
        end
        check_eq("done", 64'(done), 64'd1);
        repeat (4) @(negedge clock);
        check_eq("total", total, exp_total);
        check_eq("line_count", 64'(line_count), 64'(exp_cnt));
        check_eq("err_len", 64'(err_len), 64'(exp_err));
        check_eq("newline_pulses", 64'(nl_seen), 64'(exp_lines));
        check_eq("ready_in_done", 64'(char_ready), 64'd0);
        $display("stream k=%0d bytes=%0d: total=%0d lines=%0d err=%0d", k, stream_q.size(),
                 total, line_count, err_len);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        do_reset();

        build_example();
        run_stream(2);
        check_eq("example_k2_total", total, 64'd357);
        check_eq("example_k2_lines", 64'(line_count), 64'd4);

        do_reset();
        build_example();
        run_stream(12);
        check_eq("example_k12_total", total, 64'd3121910778619);

        do_reset();
        stream_q.delete();
        add_str("987654321111111\r\n\r\n");
        add_str("811111111111119\r\n\n");
        add_str("234234234234278\r\n");
        add_str("818181911112111");
        run_stream(2);
        check_eq("crlf_total", total, 64'd357);
        check_eq("crlf_lines", 64'(line_count), 64'd4);

        do_reset();
        stream_q.delete();
        add_str("12345\n987654321111111\n");
        run_stream(2);
        check_eq("short_total", total, CHECK_MODE ? 64'd98 : 64'd143);
        check_eq("short_lines", 64'(line_count), CHECK_MODE ? 64'd1 : 64'd2);
        check_eq("short_err", 64'(err_len), CHECK_MODE ? 64'd1 : 64'd0);

        for (int r = 0; r < 12; r++) begin
            do_reset();
            build_random();
            run_stream($urandom_range(1, 12));
        end

        // Reset in the middle of the third line, then replay the whole input.
        do_reset();
        build_example();
        sel_k = 2;
        for (int i = 0; i < 40; i++) send_byte(stream_q[i], 1'b0);
        do_reset();
        run_stream(2);
        check_eq("post_reset_total", total, 64'd357);
        check_eq("post_reset_lines", 64'(line_count), 64'd4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1, "bench timeout");
    end
endmodule

// File: doc/aoc3_line_sequencer.md
Name: aoc3_line_sequencer

Overview:
- Front-end controller for the day-3 digit selector datapath (`top`: `data_in`/`data_in_valid`/`newline`/`nums_left` in, `data_out`/`data_out_valid` out).
- Consumes a raw ASCII byte stream and converts digits. It drives one digit per cycle into the selector with the correct `nums_left`, and closes each line with a `newline` pulse.
- Waits for the selector's line result and accumulates the puzzle total. It reports done after the last line.

Parameters:
- LINE_LEN, 15, digits per input line.
- SUM_WIDTH, 64, width of the running total.
- `DATA_WIDTH` (from common.svh): width of selector data paths. This is a macro, not a parameter.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- char_in  in  8  ASCII byte
- char_valid  in  1  char_in valid
- char_last  in  1  marks final byte of input; qualified by char_valid
- char_ready  out  1  sequencer accepts char_in this cycle
- sel_data_in  out  DATA_WIDTH  digit value 0-9 to selector
- sel_data_in_valid  out  1  digit strobe
- sel_nums_left  out  DATA_WIDTH  digits remaining in line after this one
- sel_newline  out  1  one-cycle end-of-line pulse to selector
- sel_data_out  in  DATA_WIDTH  selector line result
- sel_data_out_valid  in  1  result strobe
- total  out  SUM_WIDTH  running sum of line results
- line_count  out  16  lines summed
- done  out  1  all input consumed and final result summed
- err_len  out  1  sticky line-length error (see Optional Feature)

Behaviour:
- Reset (async, reset_n=0):
  - state=FEED; col=0; total=0; line_count=0.
  - All sel_* outputs 0; done=0; err_len=0; char_ready=0 during reset.
- States:
  - FEED: char_ready=1.
  - DRAIN: char_ready=0; waiting for sel_data_out_valid.
  - DONE: char_ready=0; done=1.
- Transfer rule: a byte is consumed when char_valid && char_ready.
- Consumed byte '0'..'9' (0x30-0x39):
  - If col<LINE_LEN: next cycle sel_data_in=char_in-0x30, sel_data_in_valid=1, sel_nums_left=LINE_LEN-1-col; then col++.
  - If col>=LINE_LEN: digit dropped; nothing forwarded.
  - Latency is one cycle, registered. sel_data_in_valid is high exactly one cycle per forwarded digit.
- Consumed 0x0A:
  - If col>0: next cycle sel_newline=1 for one cycle, col:=0, state:=DRAIN.
  - If col==0 (empty line): ignored; state unchanged.
- Any other byte (e.g. 0x0D, space): consumed and ignored.
- DRAIN, on sel_data_out_valid:
  - total += zero-extended sel_data_out, wrapping modulo 2^SUM_WIDTH; line_count++.
  - Next state: DONE if the line was closed by an end flag, else FEED.
- sel_data_out_valid outside DRAIN is ignored; no accumulate.
- char_last on the consumed byte:
  - Digit with col>0 after consumption: an implicit newline is generated (sel_newline pulses in the cycle after the digit strobe), then DRAIN→DONE.
  - 0x0A with col>0: DRAIN→DONE.
  - Otherwise (empty/ignored byte, col==0): go straight to DONE.
- DONE holds until reset. total and line_count are stable and readable.
- Reset mid-line or mid-DRAIN discards the partial line. The selector is reset by the same reset_n (top level inverts it for `top`).

Optional Feature:
- Macro: AOC3_LINE_CHECK_EN.
- Defined:
  - At line close, if col != LINE_LEN (short line), or if any digit was dropped (long line), err_len is set sticky.
  - The selector is still drained, but that line's result is not added and line_count is not incremented.
- Undefined:
  - err_len tied 0.
  - Short lines are summed as-is; long-line excess digits are silently dropped.

Decomposition:
- Shared package aoc3_pkg:
  - state enum (FEED, DRAIN, DONE)
  - ASCII constants (CH_ZERO=8'h30, CH_NINE=8'h39, CH_LF=8'h0A)
  - digit-check/convert function
- Single optional sub-module aoc3_sum_acc (accumulate + line counter with enable). Otherwise the block is flat.

Test Plan:
- Stimulus: AoC example, 4 lines of 15 ("987654321111111", "811111111111119", "234234234234278", "818181911112111"), each '\n'-terminated, last LF with char_last, selector k=2.
  - Response: results 98, 89, 78, 92; total=357; line_count=4; done=1.
- Same example with 12-digit selector → total=3121910778619.
- First line digit-by-digit:
  - sel_nums_left sequence is 14,13,...,0.
  - sel_newline pulses exactly once, the cycle after the LF is consumed.
  - char_ready=0 for the entire DRAIN period.
- "\r\n" line endings, blank lines interleaved, final line without LF but char_last on its last digit → same total 357, line_count=4.
- With AOC3_LINE_CHECK_EN, input "12345\n" then a valid line "987654321111111\n" (last) → err_len=1, total=98, line_count=1. Without the macro: err_len=0, line_count=2.
- Deassert reset_n during the third line of the example, then resend the full input → the post-reset run ends with total=357, line_count=4; no stale result is accumulated.
